// File: rtl/rca_pkg.sv
// Shared definitions for the chunked ripple-carry sequencer.
//   CHUNK_W : width of the time-shared adder slice
//   state_e : sequencer FSM encoding (IDLE / RUN / DONE)
//   clog2   : constant-evaluable ceiling log2 used for counter sizing
package rca_pkg;

    localparam int CHUNK_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < value) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rca_pg_3b.sv
// 3-bit ripple-carry adder slice with group propagate/generate outputs.
// Ports:
//   a, b : 3-bit operand chunks
//   ci   : carry into bit 0
//   s    : 3-bit chunk sum
//   p    : group propagate (all three bits propagate)
//   g    : group generate (chunk produces a carry regardless of ci)
// The internal ripple carry out of bit 2 is deliberately not exported;
// users rebuild it as g | (p & ci).
module rca_pg_3b
    import rca_pkg::*;
(
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               ci,
    output logic [CHUNK_W-1:0] s,
    output logic               p,
    output logic               g
);

    logic [CHUNK_W-1:0] bp;
    logic [CHUNK_W-1:0] bg;
    logic               c1;
    logic               c2;

    assign bp = a ^ b;
    assign bg = a & b;

    assign c1 = bg[0] | (bp[0] & ci);
    assign c2 = bg[1] | (bp[1] & c1);

    assign s = bp ^ {c2, c1, ci};
    assign p = &bp;
    assign g = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0]);

endmodule

// File: rtl/rca_seq_ctrl.sv
// Multi-cycle adder: adds two WIDTH-bit operands by running one 3-bit
// rca_pg_3b slice over the operands, one chunk per cycle, LSB first.
// The carry-in of the lowest APPROX_CHUNKS chunks can be forced to zero for
// approximate accumulation; the final carry out is always the true one.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, cin captured on transfer)
//   a, b, cin           : operands and carry into chunk 0
//   out_valid/out_ready : result handshake
//   sum, cout           : result, stable while out_valid is high
//   busy                : high while an operation is in RUN or DONE
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; the sender holds its data until then, and ready never
// depends combinationally on valid.
module rca_seq_ctrl
    import rca_pkg::*;
#(
    parameter int WIDTH         = 12,
    parameter int APPROX_CHUNKS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK_W;
    localparam int IDX_W  = (NCHUNK > 1) ? clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    // FSM state is kept in state_q so checkers can bind to it directly.
    state_e             state_q;
    state_e             state_d;

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;

    logic [CHUNK_W-1:0] chunk_a;
    logic [CHUNK_W-1:0] chunk_b;
    logic [CHUNK_W-1:0] slice_s;
    logic               slice_p;
    logic               slice_g;
    logic               chunk_c;
    logic               cut_next;
    logic               accept;
    logic               run_step;
    logic               last_chunk;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign accept     = in_valid & in_ready;
    assign run_step   = (state_q == ST_RUN);
    assign last_chunk = (idx_q == LAST_IDX);

    // ------------------------------------------------------------------
    // Chunk select and slice
    // ------------------------------------------------------------------
    // cut_next tells whether the carry leaving this chunk must be dropped
    // because the next chunk still lies inside the approximate region.
    always_comb begin
        chunk_a  = '0;
        chunk_b  = '0;
        cut_next = 1'b0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IDX_W'(k)) begin
                chunk_a  = a_q[k*CHUNK_W +: CHUNK_W];
                chunk_b  = b_q[k*CHUNK_W +: CHUNK_W];
                cut_next = (k + 1 < APPROX_CHUNKS);
            end
        end
    end

    rca_pg_3b u_slice (
        .a  (chunk_a),
        .b  (chunk_b),
        .ci (carry_q),
        .s  (slice_s),
        .p  (slice_p),
        .g  (slice_g)
    );

    // Same value as the slice's internal ripple carry out of bit 2.
    assign chunk_c = slice_g | (slice_p & carry_q);

    // ------------------------------------------------------------------
    // Operand, carry, counter and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= (APPROX_CHUNKS > 0) ? 1'b0 : cin;
            idx_q   <= '0;
        end else if (run_step) begin
            for (int k = 0; k < NCHUNK; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    sum_q[k*CHUNK_W +: CHUNK_W] <= slice_s;
                end
            end
            carry_q <= cut_next ? 1'b0 : chunk_c;
            if (last_chunk) begin
                // Top carry is never cut, even when every chunk is approximate.
                cout_q <= chunk_c;
                idx_q  <= '0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
